// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: aligned line fetch into a circular issue queue.
// Define FETCH_BYPASS_EN to steer responses straight to issue when empty.
module fetch_queue_unit #(
   parameter int          FETCH_W  = 2,
   parameter int          ISSUE_W  = 2,
   parameter int          QDEPTH   = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         redirect_valid,
   input  logic [31:0]                  redirect_pc,
   output logic                         req_valid,
   output logic [31:0]                  req_addr,
   input  logic                         req_ready,
   input  logic                         resp_valid,
   input  logic [32*FETCH_W-1:0]        resp_data,
   input  logic                         resp_fault,
   output logic [$clog2(ISSUE_W+1)-1:0] issue_count,
   output logic [32*ISSUE_W-1:0]        issue_instr,
   output logic [32*ISSUE_W-1:0]        issue_pc,
   output logic [ISSUE_W-1:0]           issue_fault,
   input  logic [$clog2(ISSUE_W+1)-1:0] issue_take,
   output logic [$clog2(QDEPTH+1)-1:0]  queue_count
);

   localparam int PW = $clog2(QDEPTH);
   localparam int QW = $clog2(QDEPTH+1);
   localparam int CW = $clog2(ISSUE_W+1);
   localparam int LW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
   localparam int NW = $clog2(FETCH_W+1);
   localparam logic [31:0] LINE_BYTES = 32'(FETCH_W*4);
   localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP,
      S_HALT
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   line;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [QW-1:0] count;
   logic [QW-1:0] avail;
   logic [CW-1:0] ic;

   logic [31:0] q_instr [QDEPTH];
   logic [31:0] q_pc    [QDEPTH];
   logic        q_fault [QDEPTH];

   logic                  flush;
   logic                  resp_ok;
   logic                  byp;
   logic [LW-1:0]         off;
   logic [NW-1:0]         push_n;
   logic [NW-1:0]         skip;
   logic [32*FETCH_W-1:0] shifted;
   logic [31:0]           p_instr [FETCH_W];
   logic [31:0]           p_pc    [FETCH_W];
   logic                  p_fault [FETCH_W];

   assign line = fetch_pc & LINE_MASK;

   generate
      if (FETCH_W > 1) begin : g_off
         assign off = fetch_pc[2 +: LW];
      end else begin : g_off1
         assign off = '0;
      end
   endgenerate

   assign flush   = redirect_valid && (state != S_IDLE);
   assign resp_ok = (state == S_WAIT) && resp_valid && !flush;

`ifdef FETCH_BYPASS_EN
   assign byp = resp_ok && (count == '0);
`else
   assign byp = 1'b0;
`endif

   assign skip = byp ? NW'(issue_take) : '0;

   // Lanes below the entry offset are dropped; a fault yields one entry.
   always_comb begin
      shifted = resp_data >> {off, 5'd0};
      push_n  = '0;
      if (resp_ok)
         push_n = resp_fault ? NW'(1)
                             : NW'(FETCH_W) - NW'(off);
      for (int k = 0; k < FETCH_W; k++) begin
         p_instr[k] = resp_fault ? '0 : shifted[32*k +: 32];
         p_pc[k]    = resp_fault ? fetch_pc
                                 : line + 32'(4*(k + int'(off)));
         p_fault[k] = resp_fault;
      end
   end

   always_comb begin
      avail = byp ? QW'(push_n) : count;
      ic    = (avail > QW'(ISSUE_W)) ? CW'(ISSUE_W) : CW'(avail);
      issue_instr = '0;
      issue_pc    = '0;
      issue_fault = '0;
      for (int s = 0; s < ISSUE_W; s++) begin
         if (CW'(s) < ic) begin
            if (byp) begin
               issue_instr[32*s +: 32] = p_instr[s];
               issue_pc[32*s +: 32]    = p_pc[s];
               issue_fault[s]          = p_fault[s];
            end else begin
               issue_instr[32*s +: 32] = q_instr[head + PW'(s)];
               issue_pc[32*s +: 32]    = q_pc[head + PW'(s)];
               issue_fault[s]          = q_fault[head + PW'(s)];
            end
         end
      end
   end

   assign issue_count = ic;
   assign queue_count = count;

   assign req_valid = (state == S_REQ) &&
                      ((QW'(QDEPTH) - count) >= QW'(FETCH_W));
   assign req_addr  = req_valid ? line : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (flush) begin
         fetch_pc <= redirect_pc;
         head     <= tail;
         count    <= '0;
         // Any request still in flight now belongs to the old path.
         if ((state == S_WAIT || state == S_DROP) && !resp_valid)
            state <= S_DROP;
         else if (req_valid && req_ready)
            state <= S_DROP;
         else
            state <= S_REQ;
      end else begin
         head  <= head + (byp ? '0 : PW'(issue_take));
         tail  <= tail + PW'(push_n - skip);
         count <= count + QW'(push_n) - QW'(issue_take);
         unique case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (req_valid && req_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (resp_valid) begin
                  if (resp_fault) begin
                     state <= S_HALT;
                  end else begin
                     state    <= S_REQ;
                     fetch_pc <= line + LINE_BYTES;
                  end
               end
            end
            S_DROP: begin
               if (resp_valid)
                  state <= S_REQ;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_W; k++) begin
         if (NW'(k) < push_n && NW'(k) >= skip) begin
            q_instr[tail + PW'(k) - PW'(skip)] <= p_instr[k];
            q_pc[tail + PW'(k) - PW'(skip)]    <= p_pc[k];
            q_fault[tail + PW'(k) - PW'(skip)] <= p_fault[k];
         end
      end
   end

   take_legal: assert property (
      @(posedge clk) disable iff (reset)
      !flush |-> (issue_take <= issue_count)
   );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: randomized scoreboard bench for fetch_queue_unit.
// Reference model keeps fetched entries in a queue keyed by fetch rules.
module tb_fetch_queue_unit;

   localparam int FW = 2;
   localparam int IW = 2;
   localparam int QD = 8;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready = 1'b0;
   logic        resp_valid = 1'b0;
   logic [63:0] resp_data = '0;
   logic        resp_fault = 1'b0;
   logic [1:0]  issue_count;
   logic [63:0] issue_instr;
   logic [63:0] issue_pc;
   logic [1:0]  issue_fault;
   logic [1:0]  issue_take = '0;
   logic [3:0]  queue_count;

   fetch_queue_unit #(
      .FETCH_W(FW),
      .ISSUE_W(IW),
      .QDEPTH(QD),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_ready(req_ready),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .resp_fault(resp_fault),
      .issue_count(issue_count),
      .issue_instr(issue_instr),
      .issue_pc(issue_pc),
      .issue_fault(issue_fault),
      .issue_take(issue_take),
      .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   ent_t sb[$];
   ent_t pend[$];
   int   checks = 0;
   int   failures = 0;

   logic [31:0] fpc = '0;
   bit          busy = 0;
   bit          stale = 0;
   bit          halted = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: compare presented slots with the oldest expected entries.
   initial begin
      int n;
      int eic;
      forever begin
         @(negedge clk);
         #1;
         n   = sb.size();
         eic = (n < IW) ? n : IW;
         chk("queue_count", 32'(queue_count), 32'(n));
         chk("issue_count", 32'(issue_count), 32'(eic));
         for (int s = 0; s < IW; s++) begin
            if (s < eic) begin
               chk($sformatf("instr%0d", s),
                   issue_instr[32*s +: 32], sb[s].instr);
               chk($sformatf("pc%0d", s),
                   issue_pc[32*s +: 32], sb[s].pc);
               chk($sformatf("fault%0d", s),
                   32'(issue_fault[s]), 32'(sb[s].fault));
            end else begin
               chk($sformatf("idle_instr%0d", s),
                   issue_instr[32*s +: 32], 32'h0);
               chk($sformatf("idle_pc%0d", s),
                   issue_pc[32*s +: 32], 32'h0);
               chk($sformatf("idle_fault%0d", s),
                   32'(issue_fault[s]), 32'h0);
            end
         end
         if (!reset && redirect_valid) begin
            sb.delete();
         end else if (!reset) begin
            for (int i = 0; i < int'(issue_take); i++)
               if (sb.size() > 0) void'(sb.pop_front());
         end
         while (pend.size() > 0) sb.push_back(pend.pop_front());
      end
   end

   // One cycle of stimulus; the model advances as of the next edge.
   task automatic step(input bit          rd,
                       input logic [31:0] rpc,
                       input int          tk_in,
                       input bit          rdy,
                       input bit          rv_in,
                       input bit          rf,
                       input logic [63:0] rdat);
      bit          exp_rv;
      bit          rv;
      int          tk;
      int          lim;
      int          first;
      logic [31:0] ln;
      @(negedge clk);
      ln     = fpc - (fpc % (4*FW));
      exp_rv = !halted && !busy && (QD - sb.size() >= FW);
      chk("req_valid", 32'(req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", req_addr, ln);
      lim = (sb.size() < IW) ? sb.size() : IW;
      if (int'(issue_count) < lim) lim = int'(issue_count);
      tk = (tk_in > lim) ? lim : tk_in;
      rv = rv_in && busy;
      redirect_valid = rd;
      redirect_pc    = rpc;
      issue_take     = 2'(tk);
      req_ready      = rdy;
      resp_valid     = rv;
      resp_fault     = rv && rf;
      resp_data      = rdat;
      if (rd) begin
         fpc    = rpc;
         halted = 0;
         if (busy) begin
            if (rv) begin
               busy  = 0;
               stale = 0;
            end else begin
               stale = 1;
            end
         end else if (exp_rv && rdy) begin
            busy  = 1;
            stale = 1;
         end
      end else if (busy && rv) begin
         busy = 0;
         if (stale) begin
            stale = 0;
         end else if (rf) begin
            pend.push_back('{32'h0, fpc, 1'b1});
            halted = 1;
         end else begin
            first = int'(fpc % (4*FW)) / 4;
            for (int i = first; i < FW; i++)
               pend.push_back('{rdat[32*i +: 32],
                                ln + 32'(4*i), 1'b0});
            fpc = ln + 32'(4*FW);
         end
      end else if (!busy && exp_rv && rdy) begin
         busy  = 1;
         stale = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      issue_take     = '0;
      req_ready      = 1'b1;
      resp_valid     = 1'b1;
      resp_fault     = 1'b0;
      sb.delete();
      pend.delete();
      busy   = 0;
      stale  = 0;
      halted = 0;
      fpc    = 32'h0;
      #1;
      chk("rst_req_valid", 32'(req_valid), 32'h0);
      chk("rst_req_addr", req_addr, 32'h0);
      chk("rst_queue_count", 32'(queue_count), 32'h0);
      chk("rst_issue_count", 32'(issue_count), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      req_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] rd64;
      int          tk;
      do_reset();

      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, {32'hBBBB_0001, 32'hAAAA_0000});
      step(0, 0, 2, 0, 0, 0, 0);

      step(1, 32'h104, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, {32'h5959_5959, 32'h5858_5858});
      step(0, 0, 1, 0, 0, 0, 0);

      step(0, 0, 0, 1, 0, 0, 0);
      step(1, 32'h40, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, {32'hDEAD_0001, 32'hDEAD_0000});
      step(0, 0, 0, 1, 0, 0, 0);

      for (int r = 0; r < 4; r++) begin
         step(0, 0, 0, 0, 1, 0, {$urandom, $urandom});
         step(0, 0, 0, 1, 0, 0, 0);
      end
      step(0, 0, 2, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 2, 0, 1, 0, {$urandom, $urandom});
      repeat (4) step(0, 0, 2, 0, 0, 0, 0);

      step(1, 32'h20, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, {$urandom, $urandom});
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(1, 32'h80, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      do_reset();
      step(0, 0, 0, 1, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         rd64 = {$urandom, $urandom};
         if ((i / 400) % 2 == 1)
            tk = ($urandom % 4 == 0) ? int'($urandom_range(0, 2)) : 0;
         else
            tk = int'($urandom_range(0, 2));
         step($urandom % 25 == 0,
              $urandom & 32'h0000_0FFC,
              tk,
              $urandom % 4 != 0,
              $urandom % 3 != 0,
              $urandom % 50 == 0,
              rd64);
      end

      @(negedge clk);
      redirect_valid = 1'b0;
      resp_valid     = 1'b0;
      issue_take     = '0;
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
